quad_step_gen: RTL

QUAD_STEP_GEN -- requirements
Module: quad_step_gen

---
 rtl/quad_step_gen_pkg.sv | 26 ++
 rtl/quad_step_gen_if.sv | 18 +
 rtl/quad_phase_timer.sv | 36 +++
 rtl/quad_step_gen.sv | 122 ++++++++++++
 4 files changed

// File: rtl/quad_step_gen_pkg.sv
// quad_step_gen_pkg
//   Shared types and constants for the quadrature step generator:
//   FSM state encoding, the left/right {B,A} phase tables and a helper
//   that sizes timer counters from a cycle count.
package quad_step_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_PRESS  = 2'd2
    } state_t;

    // {B,A} per phase, entry [0] is phase 0.
    localparam logic [3:0][1:0] LEFT_TABLE  = {2'b00, 2'b01, 2'b11, 2'b10};
    localparam logic [3:0][1:0] RIGHT_TABLE = {2'b00, 2'b10, 2'b11, 2'b01};

    function automatic logic [1:0] phase_ab(input logic left, input logic [1:0] idx);
        return left ? LEFT_TABLE[idx] : RIGHT_TABLE[idx];
    endfunction

    // A 1-cycle timer still needs one counter bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/quad_step_gen_if.sv
// quad_step_gen_if
//   Command handshake into the step generator.
//   cmd_valid / cmd_ready : valid-ready handshake
//   cmd_left              : 1 = left (decrement), 0 = right
//   cmd_press             : 1 = press command (left/count ignored)
//   cmd_count             : detents to emit
interface quad_step_gen_if #(
    parameter int COUNT_W = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_left;
    logic               cmd_press;
    logic [COUNT_W-1:0] cmd_count;

    modport master (output cmd_valid, cmd_left, cmd_press, cmd_count, input cmd_ready);
    modport slave  (input cmd_valid, cmd_left, cmd_press, cmd_count, output cmd_ready);
endinterface

// File: rtl/quad_phase_timer.sv
// quad_phase_timer
//   Loadable down-counter. load reloads CYCLES-1; tc is high while enabled
//   and the count has reached zero, so a load every tc gives a period of
//   exactly CYCLES clocks.
//   clk, reset : clock, synchronous active-high reset
//   load       : reload the counter
//   en         : qualifies the terminal-count output
//   tc         : terminal count
module quad_phase_timer
    import quad_step_gen_pkg::*;
#(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);
    localparam int            W        = cnt_w(CYCLES);
    localparam logic [W-1:0]  LOAD_VAL = W'(CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = en && (cnt == '0);
endmodule

// File: rtl/quad_step_gen.sv
// quad_step_gen
//   Emulates a rotary encoder: emits Gray-coded A/B detents in either
//   direction, or holds the push switch for a fixed time.
//   clk, reset   : clock, synchronous active-high reset
//   cmd          : command handshake (slave side)
//   ROTa, ROTb   : registered encoder channels
//   ROTpress     : registered push switch, active high
//   detent_done  : one-cycle pulse on the last cycle of each detent
//
//   state  | meaning
//   IDLE   | ready for a command, outputs at rest
//   ROTATE | stepping through the four phases of each detent
//   PRESS  | ROTpress held for PRESS_CYCLES
module quad_step_gen
    import quad_step_gen_pkg::*;
#(
    parameter int PHASE_CYCLES = 1000,
    parameter int PRESS_CYCLES = 50000,
    parameter int COUNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    quad_step_gen_if.slave        cmd,
    output logic                  ROTa,
    output logic                  ROTb,
    output logic                  ROTpress,
    output logic                  detent_done
);
    state_t             state;
    logic [1:0]         phase_idx;
    logic               dir_left;
    logic [COUNT_W-1:0] remaining;

    logic accept, start_rot, start_press;
    logic last_phase, last_detent;
    logic phase_load, phase_en, phase_tc;
    logic press_en, press_tc;

    assign cmd.cmd_ready = (state == ST_IDLE);
    assign accept        = cmd.cmd_valid && (state == ST_IDLE);
    assign start_press   = accept && cmd.cmd_press;
    assign start_rot     = accept && !cmd.cmd_press && (cmd.cmd_count != '0);

    assign last_phase    = (phase_idx == 2'd3);
    assign last_detent   = (remaining <= COUNT_W'(1));
    assign phase_en      = (state == ST_ROTATE);
    assign press_en      = (state == ST_PRESS);

    // Reload at acceptance and at every phase boundary except the final one.
    assign phase_load    = start_rot || (phase_tc && !(last_phase && last_detent));

    assign detent_done   = phase_tc && last_phase;

    quad_phase_timer #(.CYCLES(PHASE_CYCLES)) u_phase_timer (
        .clk   (clk),
        .reset (reset),
        .load  (phase_load),
        .en    (phase_en),
        .tc    (phase_tc)
    );

    quad_phase_timer #(.CYCLES(PRESS_CYCLES)) u_press_timer (
        .clk   (clk),
        .reset (reset),
        .load  (start_press),
        .en    (press_en),
        .tc    (press_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            phase_idx    <= 2'd0;
            dir_left     <= 1'b0;
            remaining    <= '0;
            {ROTb, ROTa} <= 2'b00;
            ROTpress     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_rot) begin
                        state        <= ST_ROTATE;
                        remaining    <= cmd.cmd_count;
                        dir_left     <= cmd.cmd_left;
                        phase_idx    <= 2'd0;
                        {ROTb, ROTa} <= phase_ab(cmd.cmd_left, 2'd0);
                    end else if (start_press) begin
                        state        <= ST_PRESS;
                        ROTpress     <= 1'b1;
                        {ROTb, ROTa} <= 2'b00;
                    end
                end
                ST_ROTATE: begin
                    if (phase_tc) begin
                        if (!last_phase) begin
                            phase_idx    <= phase_idx + 2'd1;
                            {ROTb, ROTa} <= phase_ab(dir_left, phase_idx + 2'd1);
                        end else begin
                            if (remaining != '0) begin
                                remaining <= remaining - 1'b1;
                            end
                            phase_idx <= 2'd0;
                            if (last_detent) begin
                                state        <= ST_IDLE;
                                {ROTb, ROTa} <= 2'b00;
                            end else begin
                                {ROTb, ROTa} <= phase_ab(dir_left, 2'd0);
                            end
                        end
                    end
                end
                ST_PRESS: begin
                    if (press_tc) begin
                        state    <= ST_IDLE;
                        ROTpress <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
